// File: rtl/div_pkg.sv
// Shared encodings and constants for the iterative divider.
// Optional early-out build is selected with DIV_EARLY_OUT_EN (see iterative_divider).
package div_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned CNT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam logic [XLEN_DEFAULT-1:0] INT_MIN  = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};
  localparam logic [XLEN_DEFAULT-1:0] ALL_ONES = {XLEN_DEFAULT{1'b1}};

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  logic          neg;

  // rem < divisor holds between steps, so XLEN+1 bits suffice to read the sign of trial.
  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    trial    = rem_sh - {1'b0, divisor};
    neg      = trial[XLEN];
    rem_next = neg ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], ~neg};
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit with valid/ready request and response channels.
// Define DIV_EARLY_OUT_EN to skip iteration for divisor 0, divisor 1 and signed overflow.
module iterative_divider
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_rem_q, sel_rem_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              div0_q, div0_d, init_q;
`ifdef DIV_EARLY_OUT_EN
  logic              skip_q, skip_d;
`endif

  logic              is_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, rem_step, quo_step, quo_fix, rem_fix;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[XLEN-1];
  assign b_neg     = is_signed & divisor[XLEN-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;

  // Divide-by-zero quotient is all ones regardless of operand signs.
  assign quo_fix = div0_q ? {XLEN{1'b1}} : (q_neg_q ? -quo_q : quo_q);
  assign rem_fix = r_neg_q ? -rem_q : rem_q;

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dsr_q),
    .rem_next(rem_step),
    .quo_next(quo_step)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    sel_rem_d = sel_rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div0_d    = div0_q;
`ifdef DIV_EARLY_OUT_EN
    skip_d    = skip_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid && init_q && !flush) begin
          state_d   = CALC;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = a_mag;
          dsr_d     = b_mag;
          sel_rem_d = op[1];
          q_neg_d   = is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
          r_neg_d   = a_neg;
          div0_d    = (divisor == '0);
`ifdef DIV_EARLY_OUT_EN
          skip_d    = (divisor == '0) || (divisor == XLEN'(1)) ||
                      (is_signed && dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1);
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(XLEN)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = sel_rem_q ? rem_fix : quo_fix;
`ifdef DIV_EARLY_OUT_EN
        end else if (skip_q) begin
          // quo already holds |dividend|; only the remainder needs setting.
          skip_d = 1'b0;
          rem_d  = div0_q ? quo_q : '0;
          cnt_d  = CNT_W'(XLEN);
`endif
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (flush || rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      sel_rem_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      init_q    <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      sel_rem_q <= sel_rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      div0_q    <= div0_d;
      init_q    <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
      skip_q    <= skip_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE) && init_q;
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed cases plus randomized ops vs a reference model.
module tb_iterative_divider;
  import div_pkg::*;

  localparam int XLEN = 32;

  logic            clk, rst_n, req_valid, req_ready, flush, rsp_valid, rsp_ready, busy;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend, divisor, result;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  iterative_divider #(
    .XLEN (XLEN),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .result   (result),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = ALL_ONES;
      r = a;
    end else if (!o[0] && a == INT_MIN && b == ALL_ONES) begin
      q = INT_MIN;
      r = 0;
    end else if (o[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || b == 1 || (!o[0] && a == INT_MIN && b == ALL_ONES)) lat = 2;
`endif
    return lat;
  endfunction

  // Compare process: expectation queue filled on accept, checked on every response cycle.
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  bit          seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
      seen = 0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end else begin
          check("result vs model", result, exp_q[0]);
          if (!seen) begin
            check("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
            seen = 1;
          end
          if (flush || rsp_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            seen = 0;
          end
        end
      end else if (busy && flush) begin
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        seen = 0;
      end
      if (req_valid && req_ready && !flush) begin
        exp_q.push_back(model(op, dividend, divisor));
        lat_q.push_back(exp_lat(op, dividend, divisor));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    op        = o;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("req_ready timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) check("rsp_valid timeout", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic run_one(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    send(o, a, b);
    wait_rsp();
    check(nm, result, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    op = 2'b00; dividend = '0; divisor = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset req_ready", {31'b0, req_ready}, 32'd0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready after release", {31'b0, req_ready}, 32'd1);

    // DIVU 100/7 with consumer stalled for three cycles
    rsp_ready = 1'b0;
    send(OP_DIVU, 32'd100, 32'd7);
    wait_rsp();
    check("DIVU 100/7", result, 32'd14);
    repeat (3) begin
      @(negedge clk);
      check("held rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("held result", result, 32'd14);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rsp_valid after accept", {31'b0, rsp_valid}, 32'd0);
    check("req_ready after accept", {31'b0, req_ready}, 32'd1);

    run_one("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2);
    run_one("DIV -100/7", OP_DIV, -32'sd100, 32'd7, 32'hFFFF_FFF2);
    run_one("REM -100/7", OP_REM, -32'sd100, 32'd7, 32'hFFFF_FFFE);
    run_one("REM 100/-7", OP_REM, 32'd100, -32'sd7, 32'd2);
    run_one("DIVU x/0", OP_DIVU, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);
    run_one("DIV -5/0", OP_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF);
    run_one("REM 0x1234/0", OP_REM, 32'h1234, 32'd0, 32'h1234);
    run_one("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_one("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_one("DIV -77/1", OP_DIV, -32'sd77, 32'd1, 32'hFFFF_FFB3);

    // Flush mid-CALC: no response, ready again next cycle
    send(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("flush req_ready", {31'b0, req_ready}, 32'd1);
    repeat (40) @(negedge clk);
    run_one("DIVU 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 32'd3);

    // Flush in IDLE ignores a simultaneous request
    @(posedge clk);
    #1 begin req_valid = 1'b1; flush = 1'b1; op = OP_DIVU; dividend = 32'd8; divisor = 32'd2; end
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("idle flush busy", {31'b0, busy}, 32'd0);

    // Flush beats rsp_ready in DONE
    rsp_ready = 1'b0;
    send(OP_DIVU, 32'd20, 32'd4);
    wait_rsp();
    check("DIVU 20/4", result, 32'd5);
    @(posedge clk);
    #1 begin flush = 1'b1; rsp_ready = 1'b1; end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("done flush rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Asynchronous reset mid-CALC
    send(OP_DIVU, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst req_ready", {31'b0, req_ready}, 32'd0);
    check("async rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("async rst busy", {31'b0, busy}, 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_one("DIVU 50/5 after reset", OP_DIVU, 32'd50, 32'd5, 32'd10);

    // Randomized back-to-back traffic, consumer always ready
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 99));
      rb = 32'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      send(ro, ra, rb);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
